// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath blocks.
//   state_e    : accumulator window state (IDLE / ACC / HOLD)
//   *_DEF      : default widths and window length used by psum_accumulator
package cnn_pkg;

  localparam int unsigned DWIDTH_DEF = 16;
  localparam int unsigned KSIZE_DEF  = 9;
  localparam int unsigned AWIDTH_DEF = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/sat_relu.sv
// Combinational output transform for the partial-sum accumulator.
// Clamps a wide signed accumulator into the signed DWIDTH range, then
// optionally rectifies (negative -> 0).
//   i_acc     : signed AWIDTH accumulator value
//   i_relu_en : apply ReLU after saturation
//   o_data    : signed DWIDTH result
module sat_relu #(
  parameter int unsigned AWIDTH = 24,
  parameter int unsigned DWIDTH = 16
) (
  input  logic signed [AWIDTH-1:0] i_acc,
  input  logic                     i_relu_en,
  output logic signed [DWIDTH-1:0] o_data
);

  // Limits of the DWIDTH range, expressed at accumulator width.
  localparam logic signed [AWIDTH-1:0] MaxVal =
    {{(AWIDTH-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic signed [AWIDTH-1:0] MinVal =
    {{(AWIDTH-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

  logic signed [DWIDTH-1:0] w_sat;

  always_comb begin
    w_sat = i_acc[DWIDTH-1:0];
    if (i_acc > MaxVal) begin
      w_sat = MaxVal[DWIDTH-1:0];
    end else if (i_acc < MinVal) begin
      w_sat = MinVal[DWIDTH-1:0];
    end
  end

  always_comb begin
    o_data = w_sat;
    if (i_relu_en && w_sat[DWIDTH-1]) begin
      o_data = '0;
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Sums KSIZE signed partial-sum terms plus a bias into one saturated,
// optionally rectified output per window.
//   clk, rst_n            : clock, asynchronous active-low reset
//   clear                 : synchronous abort of the current window
//   relu_en, bias         : window options, sampled with the first term
//   in_valid/in_ready/in_data    : term input handshake
//   out_valid/out_ready/out_data : result output handshake
// The result is held in HOLD until taken; a term offered during the taking
// cycle starts the next window directly, so windows run without bubbles.
module psum_accumulator
  import cnn_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEF,
  parameter int unsigned KSIZE  = KSIZE_DEF,
  parameter int unsigned AWIDTH = AWIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     relu_en,
  input  logic signed [DWIDTH-1:0] bias,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DWIDTH-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DWIDTH-1:0] out_data
);

  localparam int unsigned CntW = $clog2(KSIZE);
  localparam logic [CntW-1:0] CntLast = CntW'(KSIZE - 1);

  if (AWIDTH < DWIDTH + $clog2(KSIZE) + 1) begin : g_awidth_check
    $error("psum_accumulator: AWIDTH too small to hold KSIZE terms plus bias");
  end

  state_e                    r_state;
  logic [CntW-1:0]           r_cnt;
  logic signed [AWIDTH-1:0]  r_acc;
  logic                      r_relu;
  logic signed [DWIDTH-1:0]  r_out_data;

  logic signed [AWIDTH-1:0]  w_data_ext;
  logic signed [AWIDTH-1:0]  w_bias_ext;
  logic signed [AWIDTH-1:0]  w_acc_first;
  logic signed [AWIDTH-1:0]  w_acc_add;
  logic signed [DWIDTH-1:0]  w_result;
  logic                      w_ready;

  assign w_data_ext  = {{(AWIDTH-DWIDTH){in_data[DWIDTH-1]}}, in_data};
  assign w_bias_ext  = {{(AWIDTH-DWIDTH){bias[DWIDTH-1]}}, bias};
  assign w_acc_first = w_bias_ext + w_data_ext;
  assign w_acc_add   = r_acc + w_data_ext;

  // The final term always arrives in ACC (KSIZE >= 2), so the latched
  // relu flag is already valid when the result is captured.
  sat_relu #(
    .AWIDTH (AWIDTH),
    .DWIDTH (DWIDTH)
  ) u_sat_relu (
    .i_acc     (w_acc_add),
    .i_relu_en (r_relu),
    .o_data    (w_result)
  );

  always_comb begin
    w_ready = 1'b0;
    unique case (r_state)
      IDLE, ACC: w_ready = 1'b1;
      HOLD:      w_ready = out_ready;
      default:   w_ready = 1'b0;
    endcase
  end

  // Gated by rst_n so the block refuses terms while held in reset.
  assign in_ready  = rst_n & w_ready;
  assign out_valid = (r_state == HOLD);
  assign out_data  = r_out_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_relu     <= 1'b0;
      r_out_data <= '0;
    end else if (clear) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_acc   <= w_acc_first;
            r_cnt   <= CntW'(1);
            r_relu  <= relu_en;
            r_state <= ACC;
          end
        end
        ACC: begin
          if (in_valid) begin
            if (r_cnt == CntLast) begin
              r_out_data <= w_result;
              r_acc      <= '0;
              r_cnt      <= '0;
              r_state    <= HOLD;
            end else begin
              r_acc <= w_acc_add;
              r_cnt <= r_cnt + CntW'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (in_valid) begin
              r_acc   <= w_acc_first;
              r_cnt   <= CntW'(1);
              r_relu  <= relu_en;
              r_state <= ACC;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_acc   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/psum_accumulator.md
PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 Parameter DWIDTH, default 16: signed width of input terms, bias and output.
REQ-002 Parameter KSIZE, default 9: number of terms summed per output window (minimum 2).
REQ-003 Parameter AWIDTH, default 24: signed accumulator width; SHALL be at least DWIDTH+$clog2(KSIZE)+1.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 clear  input  1  synchronous abort of the current window.
REQ-007 relu_en  input  1  enables ReLU on the output; sampled with the first term of a window.
REQ-008 bias  input  DWIDTH  signed bias; sampled with the first term of a window.
REQ-009 in_valid  input  1  term available.
REQ-010 in_ready  output  1  block accepts a term this cycle.
REQ-011 in_data  input  DWIDTH  signed partial-sum term.
REQ-012 out_valid  output  1  result held on out_data.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 out_data  output  DWIDTH  signed, saturated (and optionally rectified) window sum.

Function
REQ-015 A term SHALL be accepted only in a cycle where in_valid and in_ready are both 1.
REQ-016 States SHALL be IDLE, ACC and HOLD.
- IDLE: in_ready=1. The first accepted term sets acc=sext(bias)+sext(in_data) and cnt=1, then goes to ACC.
- ACC: in_ready=1. Each accepted term does acc+=sext(in_data) and cnt+=1. The KSIZE-th accepted term goes to HOLD.
- HOLD: out_valid=1 and in_ready=out_ready.
REQ-017 out_data SHALL be registered on entry to HOLD, so out_valid rises exactly 1 cycle after the KSIZE-th term is accepted.
REQ-018 Output transform, in order:
- Saturate acc to [-2^(DWIDTH-1), 2^(DWIDTH-1)-1].
- If the latched relu_en=1, replace any negative value with 0.
REQ-019 In HOLD, out_data and out_valid SHALL stay stable until out_ready=1.
REQ-020 In HOLD with out_ready=1:
- If in_valid=1, the term SHALL be accepted as the first term of a new window (bias and relu_en re-sampled) and the state goes to ACC, giving zero bubble cycles.
- If in_valid=0, the state goes to IDLE.
REQ-021 The accumulator SHALL never wrap; AWIDTH per REQ-003 guarantees this for KSIZE terms plus bias.
REQ-022 clear=1 SHALL force state IDLE, cnt=0, acc=0 and out_valid=0 on the next edge.
- clear has priority over any concurrent term acceptance or output handshake.
- A term presented with clear is discarded.
REQ-023 in_valid=0 in ACC SHALL hold cnt and acc unchanged, with no timeout.
REQ-024 The terminal cnt value SHALL be KSIZE-1 compared before increment; cnt SHALL never exceed KSIZE-1.

Reset
REQ-025 While rst_n=0: state=IDLE, cnt=0, acc=0, out_data=0, out_valid=0, and the latched relu_en=0.
REQ-026 in_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after deassertion.
REQ-027 Reset asserted mid-window or in HOLD SHALL discard all partial results; no output is produced for that window.

Structure
REQ-028 Shared package cnn_pkg SHALL hold the state enum type (IDLE/ACC/HOLD) and default constants DWIDTH_DEF=16, KSIZE_DEF=9, AWIDTH_DEF=24.
REQ-029 Saturation plus ReLU SHALL be a combinational sub-module sat_relu (parameters AWIDTH, DWIDTH), instantiated once.
REQ-030 Counter width SHALL be $clog2(KSIZE).

Verification
REQ-031 Nine terms of 100, bias=0, relu_en=0, back-to-back -> out_data=900, out_valid exactly 1 cycle after the 9th acceptance.
REQ-032 Nine terms of 30000, bias=1000 -> out_data=32767; nine terms of -30000 with relu_en=0 -> out_data=-32768.
REQ-033 Nine terms of -5, bias=0: relu_en=1 -> out_data=0; relu_en=0 -> out_data=-45.
REQ-034 Result 900 with out_ready held 0 for 5 cycles -> out_data stays 900 and in_ready stays 0. When out_ready=1 with in_valid=1, the next term is accepted that same cycle.
REQ-035 clear asserted after 4 terms of 7, then nine terms of 1 with bias=2 -> out_data=11; no output for the aborted window.
REQ-036 rst_n pulsed low in HOLD -> out_valid=0 immediately (asynchronous). After release, nine terms of 3 -> out_data=27.
